// File: rtl/cart_bank_mapper_sync.sv
// Cartridge bank-register file and address decode clocked by FastClk.
// Asynchronous cart-bus strobes are synchronised and I/O writes committed by a small FSM.
`timescale 1ns/1ps
module cart_bank_mapper_sync #(
    parameter int         ADDR_EXT_W  = 10,
    parameter int         NUM_ROM_WIN = 2,
    parameter int         RAM_MASK_W  = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] REG_BASE    = 8'hD0
) (
    input  logic                  FastClk,
    input  logic                  Reset,
    input  logic                  nSel,
    input  logic                  nIO,
    input  logic                  nWE,
    input  logic [3:0]            AddrHi,
    input  logic [7:0]            RegAddr,
    input  logic [7:0]            WriteData,
    output logic [ADDR_EXT_W-1:0] AddrExt,
    output logic                  SelRom,
    output logic                  SelRam,
    output logic [7:0]            RegOut,
    output logic                  RegAck,
    output logic                  CommitPulse,
    output logic                  Locked
);
    localparam int HI_W  = ADDR_EXT_W - 8;
    localparam int LIN_W = ADDR_EXT_W - 4;
    localparam logic [ADDR_EXT_W-1:0] ONES = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_COMMIT} state_t;

    // Reset asserts immediately but is released only on a FastClk edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       core_rst;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

    always_ff @(posedge FastClk or posedge Reset) begin
        if (Reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= rst_sync_d;
    end

    assign core_rst = rst_sync_q[1];

    logic [SYNC_STAGES-1:0]      sel_sync_q, sel_sync_d, io_sync_q, io_sync_d, we_sync_q, we_sync_d;
    logic [SYNC_STAGES-1:0][7:0] addr_dly_q, addr_dly_d, data_dly_q, data_dly_d;
    logic                        nsel_s, nio_s, nwe_s;
    state_t                      state_q, state_d;
    logic [7:0]                  cap_addr_q, cap_addr_d, cap_data_q, cap_data_d;

    logic [ADDR_EXT_W-1:0] ram_bank_q, ram_bank_d;
    logic [ADDR_EXT_W-1:0] win_q [NUM_ROM_WIN];
    logic [ADDR_EXT_W-1:0] win_d [NUM_ROM_WIN];
    logic [7:0]            linear_q, linear_d;
    logic [ADDR_EXT_W-1:0] rom_mask_q, rom_mask_d;
    logic [RAM_MASK_W-1:0] ram_mask_q, ram_mask_d;
    logic                  self_flash_q, self_flash_d, lock_q, lock_d;

    assign nsel_s = sel_sync_q[SYNC_STAGES-1];
    assign nio_s  = io_sync_q[SYNC_STAGES-1];
    assign nwe_s  = we_sync_q[SYNC_STAGES-1];

    // Address and data ride a delay line as deep as the strobe synchronisers.
    always_comb begin
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], nSel};
        io_sync_d  = {io_sync_q[SYNC_STAGES-2:0], nIO};
        we_sync_d  = {we_sync_q[SYNC_STAGES-2:0], nWE};
        addr_dly_d = {addr_dly_q[SYNC_STAGES-2:0], RegAddr};
        data_dly_d = {data_dly_q[SYNC_STAGES-2:0], WriteData};
    end

    always_comb begin
        state_d    = state_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!nsel_s && !nio_s && !nwe_s) begin
                    state_d    = ST_CAPTURE;
                    cap_addr_d = addr_dly_q[SYNC_STAGES-1];
                    cap_data_d = data_dly_q[SYNC_STAGES-1];
                end
            end
            ST_CAPTURE: begin
                if (nsel_s) begin
                    state_d = ST_IDLE;
                end else if (nwe_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    cap_addr_d = addr_dly_q[SYNC_STAGES-1];
                    cap_data_d = data_dly_q[SYNC_STAGES-1];
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    logic [NUM_ROM_WIN-1:0] wr_lo_hit, wr_hi_hit, wr_alias_hit;
    logic [NUM_ROM_WIN-1:0] rd_lo_hit, rd_hi_hit, rd_alias_hit;

    generate
        for (genvar gi = 0; gi < NUM_ROM_WIN; gi++) begin : g_win_dec
            localparam logic [7:0] LO_ADDR    = 8'(int'(REG_BASE) + 2 + 2 * gi);
            localparam logic [7:0] HI_ADDR    = 8'(int'(REG_BASE) + 3 + 2 * gi);
            localparam logic [7:0] ALIAS_ADDR = 8'(8'hC2 + gi);
            assign wr_lo_hit[gi]    = (cap_addr_q == LO_ADDR);
            assign wr_hi_hit[gi]    = (cap_addr_q == HI_ADDR);
            assign wr_alias_hit[gi] = (gi < 2) && (cap_addr_q == ALIAS_ADDR);
            assign rd_lo_hit[gi]    = (RegAddr == LO_ADDR);
            assign rd_hi_hit[gi]    = (RegAddr == HI_ADDR);
            assign rd_alias_hit[gi] = (gi < 2) && (RegAddr == ALIAS_ADDR);
        end
    endgenerate

    // Register writes land on the edge that ends the COMMIT cycle.
    always_comb begin
        ram_bank_d   = ram_bank_q;
        win_d        = win_q;
        linear_d     = linear_q;
        rom_mask_d   = rom_mask_q;
        ram_mask_d   = ram_mask_q;
        self_flash_d = self_flash_q;
        lock_d       = lock_q;
        if (state_q == ST_COMMIT) begin
            if (cap_addr_q == 8'hCE) begin
                self_flash_d = cap_data_q[0];
                lock_d       = lock_q | cap_data_q[7];
            end else if (!lock_q) begin
                if (cap_addr_q == 8'hC0) begin
                    linear_d = cap_data_q;
                end else if (cap_addr_q == 8'hC1) begin
                    ram_bank_d = ADDR_EXT_W'(cap_data_q);
                end else if (cap_addr_q == 8'hE4) begin
                    rom_mask_d[7:0] = cap_data_q;
                end else if (cap_addr_q == 8'hE5) begin
                    rom_mask_d[ADDR_EXT_W-1:8] = cap_data_q[HI_W-1:0];
                    ram_mask_d                 = RAM_MASK_W'(cap_data_q >> HI_W);
                end else if (cap_addr_q == REG_BASE) begin
                    ram_bank_d[7:0] = cap_data_q;
                end else if (cap_addr_q == 8'(int'(REG_BASE) + 1)) begin
                    ram_bank_d[ADDR_EXT_W-1:8] = cap_data_q[HI_W-1:0];
                end else begin
                    for (int k = 0; k < NUM_ROM_WIN; k++) begin
                        if (wr_alias_hit[k])   win_d[k] = ADDR_EXT_W'(cap_data_q);
                        else if (wr_lo_hit[k]) win_d[k][7:0] = cap_data_q;
                        else if (wr_hi_hit[k]) win_d[k][ADDR_EXT_W-1:8] = cap_data_q[HI_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge FastClk or posedge core_rst) begin
        if (core_rst) begin
            sel_sync_q   <= '1;
            io_sync_q    <= '1;
            we_sync_q    <= '1;
            addr_dly_q   <= '0;
            data_dly_q   <= '0;
            state_q      <= ST_IDLE;
            cap_addr_q   <= '0;
            cap_data_q   <= '0;
            ram_bank_q   <= ONES;
            for (int k = 0; k < NUM_ROM_WIN; k++) win_q[k] <= ONES;
            linear_q     <= 8'hFF;
            rom_mask_q   <= ONES;
            ram_mask_q   <= '1;
            self_flash_q <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            sel_sync_q   <= sel_sync_d;
            io_sync_q    <= io_sync_d;
            we_sync_q    <= we_sync_d;
            addr_dly_q   <= addr_dly_d;
            data_dly_q   <= data_dly_d;
            state_q      <= state_d;
            cap_addr_q   <= cap_addr_d;
            cap_data_q   <= cap_data_d;
            ram_bank_q   <= ram_bank_d;
            win_q        <= win_d;
            linear_q     <= linear_d;
            rom_mask_q   <= rom_mask_d;
            ram_mask_q   <= ram_mask_d;
            self_flash_q <= self_flash_d;
            lock_q       <= lock_d;
        end
    end

    assign CommitPulse = (state_q == ST_COMMIT);
    assign Locked      = lock_q;

    always_comb begin
        RegOut = 8'h00;
        RegAck = 1'b1;
        if (RegAddr == 8'hC0) begin
            RegOut = linear_q;
        end else if (RegAddr == 8'hC1 || RegAddr == REG_BASE) begin
            RegOut = ram_bank_q[7:0];
        end else if (RegAddr == 8'(int'(REG_BASE) + 1)) begin
            RegOut = 8'(ram_bank_q[ADDR_EXT_W-1:8]);
        end else if (RegAddr == 8'hCE) begin
            RegOut = {lock_q, 6'b000000, self_flash_q};
        end else if (RegAddr == 8'hE4) begin
            RegOut = rom_mask_q[7:0];
        end else if (RegAddr == 8'hE5) begin
            RegOut = 8'((16'(ram_mask_q) << HI_W) | 16'(rom_mask_q[ADDR_EXT_W-1:8]));
        end else begin
            RegAck = 1'b0;
            for (int k = 0; k < NUM_ROM_WIN; k++) begin
                if (rd_lo_hit[k] || rd_alias_hit[k]) begin
                    RegAck = 1'b1;
                    RegOut = win_q[k][7:0];
                end else if (rd_hi_hit[k]) begin
                    RegAck = 1'b1;
                    RegOut = 8'(win_q[k][ADDR_EXT_W-1:8]);
                end
            end
        end
    end

    // The RAM mask only trims the low bank bits; upper RAM bank bits pass through.
    always_comb begin
        SelRom  = 1'b0;
        SelRam  = 1'b0;
        AddrExt = '0;
        if (AddrHi == 4'd0) begin
            AddrExt = '0;
        end else if (AddrHi == 4'd1) begin
            if (self_flash_q) begin
                SelRom  = 1'b1;
                AddrExt = ram_bank_q & rom_mask_q;
            end else begin
                SelRam  = 1'b1;
                AddrExt = {ram_bank_q[ADDR_EXT_W-1:RAM_MASK_W], ram_bank_q[RAM_MASK_W-1:0] & ram_mask_q};
            end
        end else if (AddrHi <= 4'(1 + NUM_ROM_WIN)) begin
            SelRom = 1'b1;
            for (int k = 0; k < NUM_ROM_WIN; k++) begin
                if (AddrHi == 4'(k + 2)) AddrExt = win_q[k] & rom_mask_q;
            end
        end else begin
            SelRom  = 1'b1;
            AddrExt = {LIN_W'(linear_q), AddrHi} & rom_mask_q;
        end
    end
endmodule

// File: tb/tb_cart_bank_mapper_sync.sv
// Randomised bench for cart_bank_mapper_sync against an arithmetic model of the register map.
`timescale 1ns/1ps
module tb_cart_bank_mapper_sync;
    localparam int         W    = 10;
    localparam int         NWIN = 2;
    localparam int         RMW  = 4;
    localparam int         SS   = 2;
    localparam logic [7:0] RB   = 8'hD0;
    localparam int         RBI  = int'(RB);

    logic         FastClk = 1'b0;
    logic         Reset = 1'b1;
    logic         nSel = 1'b1, nIO = 1'b1, nWE = 1'b1;
    logic [3:0]   AddrHi = 4'd0;
    logic [7:0]   RegAddr = 8'h00, WriteData = 8'h00;
    logic [W-1:0] AddrExt;
    logic         SelRom, SelRam, RegAck, CommitPulse, Locked;
    logic [7:0]   RegOut;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int pulse_cnt = 0;

    int m_ram, m_lin, m_rom_mask, m_ram_mask, m_sf, m_lock;
    int m_win [NWIN];

    cart_bank_mapper_sync #(
        .ADDR_EXT_W(W), .NUM_ROM_WIN(NWIN), .RAM_MASK_W(RMW), .SYNC_STAGES(SS), .REG_BASE(RB)
    ) dut (
        .FastClk(FastClk), .Reset(Reset), .nSel(nSel), .nIO(nIO), .nWE(nWE),
        .AddrHi(AddrHi), .RegAddr(RegAddr), .WriteData(WriteData),
        .AddrExt(AddrExt), .SelRom(SelRom), .SelRam(SelRam), .RegOut(RegOut),
        .RegAck(RegAck), .CommitPulse(CommitPulse), .Locked(Locked)
    );

    always #5 FastClk = ~FastClk;
    always @(negedge FastClk) if (CommitPulse === 1'b1) pulse_cnt++;

    function automatic void model_reset();
        m_ram = (1 << W) - 1;
        for (int k = 0; k < NWIN; k++) m_win[k] = (1 << W) - 1;
        m_lin = 255;
        m_rom_mask = (1 << W) - 1;
        m_ram_mask = (1 << RMW) - 1;
        m_sf = 0;
        m_lock = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        int full = (1 << W) - 1;
        int hi = (1 << (W - 8)) - 1;
        if (a == 'hCE) begin
            m_sf = d % 2;
            if (d >= 128) m_lock = 1;
            return;
        end
        if (m_lock != 0) return;
        if (a == 'hC0) m_lin = d;
        else if (a == 'hC1) m_ram = d;
        else if (a == 'hE4) m_rom_mask = (m_rom_mask & full & ~255) + d;
        else if (a == 'hE5) begin
            m_rom_mask = (m_rom_mask % 256) + (d & hi) * 256;
            m_ram_mask = (d >> (W - 8)) % (1 << RMW);
        end
        else if (a == RBI) m_ram = (m_ram & full & ~255) + d;
        else if (a == RBI + 1) m_ram = (m_ram % 256) + (d & hi) * 256;
        else begin
            for (int k = 0; k < NWIN; k++) begin
                if (k < 2 && a == 'hC2 + k) m_win[k] = d;
                else if (a == RBI + 2 + 2 * k) m_win[k] = (m_win[k] & full & ~255) + d;
                else if (a == RBI + 3 + 2 * k) m_win[k] = (m_win[k] % 256) + (d & hi) * 256;
            end
        end
    endfunction

    function automatic void model_read(input int a, output int ack, output int val);
        ack = 1;
        val = 0;
        if (a == 'hC0) val = m_lin;
        else if (a == 'hC1 || a == RBI) val = m_ram % 256;
        else if (a == RBI + 1) val = m_ram / 256;
        else if (a == 'hCE) val = m_lock * 128 + m_sf;
        else if (a == 'hE4) val = m_rom_mask % 256;
        else if (a == 'hE5) val = (m_ram_mask * (1 << (W - 8)) + m_rom_mask / 256) % 256;
        else begin
            ack = 0;
            for (int k = 0; k < NWIN; k++) begin
                if (a == RBI + 2 + 2 * k || (k < 2 && a == 'hC2 + k)) begin
                    ack = 1;
                    val = m_win[k] % 256;
                end else if (a == RBI + 3 + 2 * k) begin
                    ack = 1;
                    val = m_win[k] / 256;
                end
            end
        end
    endfunction

    function automatic void model_decode(input int ah, output int rom, output int ram, output int ext);
        int rmm = (1 << RMW) - 1;
        rom = 0; ram = 0; ext = 0;
        if (ah == 1) begin
            if (m_sf != 0) begin
                rom = 1;
                ext = m_ram & m_rom_mask;
            end else begin
                ram = 1;
                ext = (m_ram - (m_ram % (rmm + 1))) + ((m_ram % (rmm + 1)) & m_ram_mask);
            end
        end else if (ah >= 2 && ah <= 1 + NWIN) begin
            rom = 1;
            ext = m_win[ah - 2] & m_rom_mask;
        end else if (ah > 1 + NWIN) begin
            rom = 1;
            ext = ((m_lin % (1 << (W - 4))) * 16 + ah) & m_rom_mask;
        end
    endfunction

    function automatic int pick_addr();
        int r = $urandom_range(0, 11 + 2 * NWIN);
        case (r)
            0: return 'hC0;
            1: return 'hC1;
            2: return 'hC2;
            3: return 'hC3;
            4: return 'hCE;
            5: return 'hE4;
            6: return 'hE5;
            7: return RBI;
            8: return RBI + 1;
            default: begin
                if (r <= 8 + 2 * NWIN) return RBI + 2 + (r - 9);
                return $urandom_range(0, 255);
            end
        endcase
    endfunction

    // mode 0: normal write, 1: nSel released a cycle before nWE, 2: both released together
    task automatic bus_write(input int a, input int d, input int mode, output int pulses, output int lat);
        int p0;
        @(posedge FastClk); #1;
        RegAddr = 8'(a); WriteData = 8'(d); nSel = 1'b0; nIO = 1'b0;
        @(posedge FastClk); #1;
        nWE = 1'b0;
        repeat (3) @(posedge FastClk);
        #1;
        if (mode == 1) begin
            nSel = 1'b1;
            @(posedge FastClk); #1;
        end
        if (mode == 2) nSel = 1'b1;
        nWE = 1'b1;
        p0 = pulse_cnt;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge FastClk); #1;
            if (CommitPulse === 1'b1 && lat < 0) lat = i;
        end
        nSel = 1'b1; nIO = 1'b1;
        @(posedge FastClk); #1;
        pulses = pulse_cnt - p0;
        $display("write addr=%02h data=%02h mode=%0d pulses=%0d latency=%0d", a, d, mode, pulses, lat);
    endtask

    task automatic test_reset();
        int ack, val, rom, ram, ext;
        Reset = 1'b1;
        repeat (3) @(posedge FastClk);
        #1 Reset = 1'b0;
        repeat (4) @(posedge FastClk);
        #1;
        model_reset();
        chk_cnt++;
        if (CommitPulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", CommitPulse); else pass_cnt++;
        chk_cnt++;
        if (Locked !== 1'b0) $display("FAIL reset_lock got %b want 0", Locked); else pass_cnt++;
        for (int a = 0; a < 256; a++) begin
            RegAddr = 8'(a); #1;
            model_read(a, ack, val);
            chk_cnt++;
            if (RegAck !== 1'(ack) || RegOut !== 8'(val))
                $display("FAIL reset_read_%02h got ack=%b data=%02h want ack=%0d data=%02h", a, RegAck, RegOut, ack, val);
            else pass_cnt++;
        end
        for (int ah = 0; ah < 16; ah++) begin
            AddrHi = 4'(ah); #1;
            model_decode(ah, rom, ram, ext);
            chk_cnt++;
            if (SelRom !== 1'(rom) || SelRam !== 1'(ram) || AddrExt !== W'(ext))
                $display("FAIL reset_decode_%0d got rom=%b ram=%b ext=%03h want rom=%0d ram=%0d ext=%03h",
                         ah, SelRom, SelRam, AddrExt, rom, ram, ext);
            else pass_cnt++;
        end
    endtask

    task automatic test_window_write();
        int pulses, lat, rom, ram, ext;
        int wa [3] = '{RBI + 4, RBI + 5, 'hE4};
        int wd [3] = '{'h45, 'h01, 'h0F};
        for (int i = 0; i < 3; i++) begin
            bus_write(wa[i], wd[i], 0, pulses, lat);
            model_write(wa[i], wd[i]);
            chk_cnt++;
            if (pulses !== 1 || lat !== SS + 1)
                $display("FAIL win_commit_%02h got pulses=%0d latency=%0d want 1 and %0d", wa[i], pulses, lat, SS + 1);
            else pass_cnt++;
            AddrHi = 4'd3; #1;
            model_decode(3, rom, ram, ext);
            chk_cnt++;
            if (SelRom !== 1'(rom) || AddrExt !== W'(ext))
                $display("FAIL win_decode_%0d got rom=%b ext=%03h want rom=%0d ext=%03h", i, SelRom, AddrExt, rom, ext);
            else pass_cnt++;
        end
    endtask

    task automatic test_linear_alias();
        int pulses, lat, ack, val, rom, ram, ext;
        int wa [3] = '{'hC0, RBI + 3, 'hC2};
        int wd [3] = '{'h12, 'h02, 'h80};
        for (int i = 0; i < 3; i++) begin
            bus_write(wa[i], wd[i], 0, pulses, lat);
            model_write(wa[i], wd[i]);
            chk_cnt++;
            if (pulses !== 1) $display("FAIL alias_pulse_%02h got %0d want 1", wa[i], pulses); else pass_cnt++;
        end
        RegAddr = 8'(RBI + 3); #1;
        model_read(RBI + 3, ack, val);
        chk_cnt++;
        if (RegOut !== 8'(val)) $display("FAIL alias_clears_hi got %02h want %02h", RegOut, val); else pass_cnt++;
        AddrHi = 4'd9; #1;
        model_decode(9, rom, ram, ext);
        chk_cnt++;
        if (SelRom !== 1'(rom) || AddrExt !== W'(ext))
            $display("FAIL linear_decode got rom=%b ext=%03h want rom=%0d ext=%03h", SelRom, AddrExt, rom, ext);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int pulses, lat, ack, val;
        for (int mode = 1; mode <= 2; mode++) begin
            bus_write(RBI, 'h00, mode, pulses, lat);
            chk_cnt++;
            if (pulses !== 0) $display("FAIL abort_pulse_m%0d got %0d want 0", mode, pulses); else pass_cnt++;
            RegAddr = RB; #1;
            model_read(RBI, ack, val);
            chk_cnt++;
            if (RegOut !== 8'(val)) $display("FAIL abort_data_m%0d got %02h want %02h", mode, RegOut, val); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int p0, ack, val;
        int d1 = $urandom_range(0, 255);
        int d2 = $urandom_range(0, 255);
        p0 = pulse_cnt;
        @(posedge FastClk); #1;
        RegAddr = 8'(RBI + 2); WriteData = 8'(d1); nSel = 1'b0; nIO = 1'b0;
        @(posedge FastClk); #1;
        nWE = 1'b0;
        repeat (3) @(posedge FastClk);
        #1 nWE = 1'b1;
        repeat (2) @(posedge FastClk);
        #1 nWE = 1'b0; RegAddr = 8'(RBI + 3); WriteData = 8'(d2);
        repeat (3) @(posedge FastClk);
        #1 nWE = 1'b1;
        repeat (8) @(posedge FastClk);
        #1 nSel = 1'b1; nIO = 1'b1;
        @(posedge FastClk); #1;
        model_write(RBI + 2, d1);
        model_write(RBI + 3, d2);
        $display("back_to_back d1=%02h d2=%02h pulses=%0d", d1, d2, pulse_cnt - p0);
        chk_cnt++;
        if (pulse_cnt - p0 !== 2) $display("FAIL b2b_pulses got %0d want 2", pulse_cnt - p0); else pass_cnt++;
        for (int a = RBI + 2; a <= RBI + 3; a++) begin
            RegAddr = 8'(a); #1;
            model_read(a, ack, val);
            chk_cnt++;
            if (RegOut !== 8'(val)) $display("FAIL b2b_read_%02h got %02h want %02h", a, RegOut, val); else pass_cnt++;
        end
    endtask

    task automatic test_random(input int n, input bit allow_lock);
        int a, d, mode, pulses, lat, ack, val, rom, ram, ext, ah;
        for (int i = 0; i < n; i++) begin
            a = pick_addr();
            d = $urandom_range(0, 255);
            if (a == 'hCE && !allow_lock) d = d % 128;
            mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            bus_write(a, d, mode, pulses, lat);
            if (mode == 0) model_write(a, d);
            chk_cnt++;
            if (pulses !== (mode == 0 ? 1 : 0) || (mode == 0 && lat !== SS + 1))
                $display("FAIL rand_commit_%0d got pulses=%0d latency=%0d mode=%0d", i, pulses, lat, mode);
            else pass_cnt++;
            RegAddr = 8'(a); #1;
            model_read(a, ack, val);
            chk_cnt++;
            if (RegAck !== 1'(ack) || RegOut !== 8'(val))
                $display("FAIL rand_read_%02h got ack=%b data=%02h want ack=%0d data=%02h", a, RegAck, RegOut, ack, val);
            else pass_cnt++;
            ah = $urandom_range(0, 15);
            AddrHi = 4'(ah); #1;
            model_decode(ah, rom, ram, ext);
            chk_cnt++;
            if (SelRom !== 1'(rom) || SelRam !== 1'(ram) || AddrExt !== W'(ext))
                $display("FAIL rand_decode_%0d got rom=%b ram=%b ext=%03h want rom=%0d ram=%0d ext=%03h",
                         ah, SelRom, SelRam, AddrExt, rom, ram, ext);
            else pass_cnt++;
        end
    endtask

    task automatic test_lock();
        int pulses, lat, ack, val, rom, ram, ext;
        bus_write('hCE, 'h81, 0, pulses, lat);
        model_write('hCE, 'h81);
        AddrHi = 4'd1; #1;
        model_decode(1, rom, ram, ext);
        chk_cnt++;
        if (Locked !== 1'b1 || SelRom !== 1'(rom) || SelRam !== 1'(ram) || AddrExt !== W'(ext))
            $display("FAIL lock_set got lock=%b rom=%b ram=%b ext=%03h want 1 %0d %0d %03h",
                     Locked, SelRom, SelRam, AddrExt, rom, ram, ext);
        else pass_cnt++;
        bus_write(RBI, 'h00, 0, pulses, lat);
        model_write(RBI, 'h00);
        RegAddr = RB; #1;
        model_read(RBI, ack, val);
        chk_cnt++;
        if (pulses !== 1 || RegOut !== 8'(val))
            $display("FAIL lock_ignore got pulses=%0d data=%02h want 1 and %02h", pulses, RegOut, val);
        else pass_cnt++;
        bus_write('hCE, 'h00, 0, pulses, lat);
        model_write('hCE, 'h00);
        AddrHi = 4'd1; #1;
        model_decode(1, rom, ram, ext);
        chk_cnt++;
        if (Locked !== 1'b1 || SelRam !== 1'(ram) || AddrExt !== W'(ext))
            $display("FAIL lock_sticky got lock=%b ram=%b ext=%03h want 1 %0d %03h", Locked, SelRam, AddrExt, ram, ext);
        else pass_cnt++;
        test_random(10, 1'b1);
        Reset = 1'b1;
        repeat (2) @(posedge FastClk);
        #1 Reset = 1'b0;
        repeat (4) @(posedge FastClk);
        #1;
        model_reset();
        chk_cnt++;
        if (Locked !== 1'b0) $display("FAIL lock_reset got %b want 0", Locked); else pass_cnt++;
    endtask

    task automatic test_reset_mid_capture();
        int pulses, lat, p0, ack, val;
        bus_write(RBI, 'h5A, 0, pulses, lat);
        model_write(RBI, 'h5A);
        p0 = pulse_cnt;
        @(posedge FastClk); #1;
        RegAddr = RB; WriteData = 8'h33; nSel = 1'b0; nIO = 1'b0; nWE = 1'b0;
        repeat (5) @(posedge FastClk);
        #2 Reset = 1'b1;
        #1;
        chk_cnt++;
        if (CommitPulse !== 1'b0) $display("FAIL midcap_pulse got %b want 0", CommitPulse); else pass_cnt++;
        nWE = 1'b1;
        @(posedge FastClk); #1;
        nSel = 1'b1; nIO = 1'b1;
        repeat (3) @(posedge FastClk);
        #1 Reset = 1'b0;
        repeat (8) @(posedge FastClk);
        #1;
        model_reset();
        $display("reset_mid_capture pulses=%0d", pulse_cnt - p0);
        chk_cnt++;
        if (pulse_cnt - p0 !== 0) $display("FAIL midcap_commits got %0d want 0", pulse_cnt - p0); else pass_cnt++;
        for (int a = 0; a < 256; a++) begin
            RegAddr = 8'(a); #1;
            model_read(a, ack, val);
            chk_cnt++;
            if (RegAck !== 1'(ack) || RegOut !== 8'(val))
                $display("FAIL midcap_read_%02h got ack=%b data=%02h want ack=%0d data=%02h", a, RegAck, RegOut, ack, val);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_window_write();
        test_linear_alias();
        test_abort();
        test_back_to_back();
        test_random(40, 1'b0);
        test_lock();
        test_reset_mid_capture();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
